// File: rtl/q_sched_pkg.sv
// Shared types and helpers for the Q-function scheduler.
// FSM states, default data width and id-width helper.
package q_sched_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/q_func_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or
// after ptr, scanning upward with wrap.
module rr_arbiter
  import q_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any_req
);

  always_comb begin
    int   j;
    logic found;
    grant   = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/q_func_scheduler.sv
// Time-shares one Q-function core between NREQ requesters:
// grant, issue, wait CORE_LAT, then answer over valid/ready.
module q_func_scheduler
  import q_sched_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int CORE_LAT = 8,
  localparam int IW       = clog2(NREQ)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_x,
  input  logic [NREQ*DATA_W-1:0] req_t,
  input  logic [NREQ*DATA_W-1:0] req_n,
  input  logic [NREQ*DATA_W-1:0] req_alpha,
  output logic [DATA_W-1:0]      core_x,
  output logic [DATA_W-1:0]      core_t,
  output logic [DATA_W-1:0]      core_n,
  output logic [DATA_W-1:0]      core_alpha,
  output logic                   core_inform_valid,
  input  logic [DATA_W-1:0]      core_q,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IW-1:0]          rsp_id,
  output logic [DATA_W-1:0]      rsp_q,
  output logic                   busy
);

  localparam int CW = clog2(CORE_LAT) + 1;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gid;
  logic [IW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_grant;
  logic            arb_any;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  // gated by aresetn so no accept is signalled during reset
  assign req_ready =
    (state == IDLE && aresetn) ? arb_grant : '0;
  assign core_inform_valid = (state == ISSUE);
  assign busy              = (state != IDLE);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (arb_any) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (cnt == '0) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr        <= '0;
      gid        <= '0;
      cnt        <= '0;
      core_x     <= '0;
      core_t     <= '0;
      core_n     <= '0;
      core_alpha <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_q      <= '0;
    end else begin
      unique case (state)
        IDLE: if (arb_any) begin
          gid <= arb_idx;
          ptr <= (arb_idx == IW'(NREQ - 1)) ?
                 '0 : arb_idx + 1'b1;
          core_x     <= req_x[arb_idx*DATA_W +: DATA_W];
          core_t     <= req_t[arb_idx*DATA_W +: DATA_W];
          core_n     <= req_n[arb_idx*DATA_W +: DATA_W];
          core_alpha <= req_alpha[arb_idx*DATA_W +: DATA_W];
        end
        ISSUE: cnt <= CW'(CORE_LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gid;
            rsp_q     <= core_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
